scumvcontroller_tx_arbiter: RTL and testbench

SCUMVCONTROLLER_TX_ARBITER -- requirements
Module: scumvcontroller_tx_arbiter

---
 rtl/scumvcontroller_pkg.sv | 32 +++
 rtl/scumvcontroller_rr_pick.sv | 33 +++
 rtl/scumvcontroller_tx_arbiter.sv | 178 +++++++++++++++++
 tb/tb_scumvcontroller_tx_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/scumvcontroller_pkg.sv
// Shared definitions for the scumvcontroller transmit path.
// Holds the arbiter state encoding, requester IDs, packet tag bytes and the
// pad byte, plus a helper mapping a requester ID to its tag.
package scumvcontroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2,
    ST_PAD  = 2'd3
  } tx_state_t;

  localparam logic [1:0] ID_ASC  = 2'd0;
  localparam logic [1:0] ID_STL  = 2'd1;
  localparam logic [1:0] ID_DBG  = 2'd2;
  localparam logic [1:0] ID_NONE = 2'd3;

  localparam logic [7:0] TAG_ASC  = 8'h61; // 'a'
  localparam logic [7:0] TAG_STL  = 8'h73; // 's'
  localparam logic [7:0] TAG_DBG  = 8'h64; // 'd'
  localparam logic [7:0] PAD_BYTE = 8'hEE;

  function automatic logic [7:0] tag_for(input logic [1:0] id);
    case (id)
      ID_ASC:  tag_for = TAG_ASC;
      ID_STL:  tag_for = TAG_STL;
      ID_DBG:  tag_for = TAG_DBG;
      default: tag_for = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/scumvcontroller_rr_pick.sv
// 3-way round-robin pick.
// Ports:
//   req        - request vector, bit n = requester ID n
//   last_grant - ID granted most recently; search starts at (last_grant+1) mod 3
//   any        - at least one request is set
//   pick       - chosen requester ID (ID_NONE when no request)
module scumvcontroller_rr_pick
  import scumvcontroller_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic       any,
  output logic [1:0] pick
);

  logic [3:0] req_ext;
  logic [1:0] cand0, cand1, cand2;

  always_comb begin
    req_ext = {1'b0, req};
    // An out-of-range last_grant restarts the search at ASC.
    cand0 = (last_grant >= 2'd2) ? 2'd0 : last_grant + 2'd1;
    cand1 = (cand0 == 2'd2) ? 2'd0 : cand0 + 2'd1;
    cand2 = (cand0 == 2'd0) ? 2'd2 : cand0 - 2'd1;
    any   = |req;
    pick  = ID_NONE;
    // Lowest-priority candidate first so the highest-priority one wins.
    if (req_ext[cand2]) pick = cand2;
    if (req_ext[cand1]) pick = cand1;
    if (req_ext[cand0]) pick = cand0;
  end

endmodule

// File: rtl/scumvcontroller_tx_arbiter.sv
// Transmit arbiter: merges ASC, STL and debug response packets into one byte
// stream toward the outgoing UART FIFO. Each packet is a tag byte followed by
// LEN data bytes passed through combinationally. A requester that stalls
// mid-packet for too long has the rest of its packet padded with 0xEE.
// Ports:
//   clk, reset                  - clock, asynchronous active-low reset
//   {asc,stl,dbg}_valid/_data   - requester byte streams
//   {asc,stl,dbg}_ready         - requester byte accepted
//   out_valid/out_data/out_ready- outgoing FIFO byte stream
//   grant_id                    - 0=ASC 1=STL 2=DBG 3=none
//   busy                        - packet in progress
//   timeout_count               - saturating count of padded packets
module scumvcontroller_tx_arbiter
  import scumvcontroller_pkg::*;
#(
  parameter int unsigned ASC_LEN        = 1,
  parameter int unsigned STL_LEN        = 16,
  parameter int unsigned DBG_LEN        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       asc_valid,
  input  logic [7:0] asc_data,
  output logic       asc_ready,
  input  logic       stl_valid,
  input  logic [7:0] stl_data,
  output logic       stl_ready,
  input  logic       dbg_valid,
  input  logic [7:0] dbg_data,
  output logic       dbg_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic [7:0] timeout_count
);

  localparam logic [7:0] ASC_LAST = 8'(ASC_LEN - 1);
  localparam logic [7:0] STL_LAST = 8'(STL_LEN - 1);
  localparam logic [7:0] DBG_LAST = 8'(DBG_LEN - 1);

  localparam int unsigned     SW          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0]   STALL_LIMIT = SW'(TIMEOUT_CYCLES - 1);

  tx_state_t     state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    last_q,  last_d;
  logic [7:0]    cnt_q,   cnt_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [7:0]    tmo_q,   tmo_d;

  logic       rr_any;
  logic [1:0] rr_pick;
  logic       g_valid;
  logic [7:0] g_data;
  logic [7:0] last_idx;

  scumvcontroller_rr_pick u_rr_pick (
    .req        ({dbg_valid, stl_valid, asc_valid}),
    .last_grant (last_q),
    .any        (rr_any),
    .pick       (rr_pick)
  );

  // Granted requester's stream and index of its final byte.
  always_comb begin
    g_valid  = 1'b0;
    g_data   = '0;
    last_idx = ASC_LAST;
    case (grant_q)
      ID_ASC: begin g_valid = asc_valid; g_data = asc_data; last_idx = ASC_LAST; end
      ID_STL: begin g_valid = stl_valid; g_data = stl_data; last_idx = STL_LAST; end
      ID_DBG: begin g_valid = dbg_valid; g_data = dbg_data; last_idx = DBG_LAST; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= ID_NONE;
      last_q  <= ID_DBG;
      cnt_q   <= '0;
      stall_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    stall_d   = stall_q;
    tmo_d     = tmo_q;
    out_valid = 1'b0;
    out_data  = '0;
    asc_ready = 1'b0;
    stl_ready = 1'b0;
    dbg_ready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          grant_d = rr_pick;
          last_d  = rr_pick;
          cnt_d   = '0;
          state_d = ST_TAG;
        end
      end

      ST_TAG: begin
        out_valid = 1'b1;
        out_data  = tag_for(grant_q);
        if (out_ready) begin
          stall_d = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        out_valid = g_valid;
        out_data  = g_data;
        case (grant_q)
          ID_ASC:  asc_ready = out_ready;
          ID_STL:  stl_ready = out_ready;
          ID_DBG:  dbg_ready = out_ready;
          default: ;
        endcase
        if (g_valid && out_ready) begin
          cnt_d   = cnt_q + 8'd1;
          stall_d = '0;
          if (cnt_q == last_idx) begin
            grant_d = ID_NONE;
            state_d = ST_IDLE;
          end
        end else if (!g_valid) begin
          // Backpressure with valid data held is not a stall; only an
          // absent requester byte counts toward the timeout.
          if (stall_q == STALL_LIMIT) begin
            state_d = ST_PAD;
            tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end

      ST_PAD: begin
        out_valid = 1'b1;
        out_data  = PAD_BYTE;
        if (out_ready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == last_idx) begin
            grant_d = ID_NONE;
            state_d = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_count = tmo_q;

endmodule

// File: tb/tb_scumvcontroller_tx_arbiter.sv
module tb_scumvcontroller_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       asc_valid, stl_valid, dbg_valid;
  logic [7:0] asc_data, stl_data, dbg_data;
  logic       asc_ready, stl_ready, dbg_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [1:0] grant_id;
  logic       busy;
  logic [7:0] timeout_count;

  scumvcontroller_tx_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .asc_valid     (asc_valid),
    .asc_data      (asc_data),
    .asc_ready     (asc_ready),
    .stl_valid     (stl_valid),
    .stl_data      (stl_data),
    .stl_ready     (stl_ready),
    .dbg_valid     (dbg_valid),
    .dbg_data      (dbg_data),
    .dbg_ready     (dbg_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Requester source model and output capture
  logic [7:0] asc_q[$], stl_q[$], dbg_q[$];
  logic [7:0] out_q[$], tag_q[$];
  logic [1:0] gid_q[$];
  bit asc_en, stl_en, dbg_en;
  bit or_level, or_toggle, or_phase;
  bit seen_idle;
  int pad_ready_seen;

  typedef struct {
    logic       av;
    logic       sv;
    logic [7:0] din;
    logic       ordy;
    logic       ov;
    logic [7:0] od;
    logic       ar;
    logic       sr;
    logic       bsy;
    logic [1:0] gid;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    asc_valid = asc_en && (asc_q.size() > 0);
    asc_data  = asc_valid ? asc_q[0] : 8'h00;
    stl_valid = stl_en && (stl_q.size() > 0);
    stl_data  = stl_valid ? stl_q[0] : 8'h00;
    dbg_valid = dbg_en && (dbg_q.size() > 0);
    dbg_data  = dbg_valid ? dbg_q[0] : 8'h00;
    out_ready = or_toggle ? or_phase : or_level;
    #1;
    if (!busy) seen_idle = 1'b1;
    if (out_valid && out_ready) begin
      out_q.push_back(out_data);
      if (busy && seen_idle) begin
        tag_q.push_back(out_data);
        gid_q.push_back(grant_id);
        seen_idle = 1'b0;
      end
    end
    if (asc_valid && asc_ready) asc_q.delete(0);
    if (stl_valid && stl_ready) stl_q.delete(0);
    if (dbg_valid && dbg_ready) dbg_q.delete(0);
    if (busy && out_valid && out_data == 8'hEE && dbg_ready) pad_ready_seen++;
    if (or_toggle) or_phase = ~or_phase;
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string name);
    chk(name, {17'b0, out_valid, asc_ready, stl_ready, dbg_ready, busy, grant_id, timeout_count},
              {17'b0, 5'b0, 2'd3, 8'd0});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    asc_en = 0; stl_en = 0; dbg_en = 0;
    asc_q.delete(); stl_q.delete(); dbg_q.delete();
    out_q.delete(); tag_q.delete(); gid_q.delete();
    asc_valid = 0; stl_valid = 0; dbg_valid = 0;
    asc_data = 0; stl_data = 0; dbg_data = 0;
    out_ready = 0; or_level = 0; or_toggle = 0; or_phase = 1;
    seen_idle = 1'b1; pad_ready_seen = 0;
    @(negedge clk);
    #1;
    chk_reset_outs("reset_state");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    //            av  sv  din    or   ov  od     ar  sr  bsy gid
    tbl[0] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[1] = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h61, 1'b0, 1'b0, 1'b1, 2'd0};
    tbl[3] = '{1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[4] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 2'd0};
    tbl[5] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd3};
    tbl[6] = '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b1, 8'h73, 1'b0, 1'b0, 1'b1, 2'd1};
    tbl[7] = '{1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1, 2'd1};

    @(negedge clk);
    do_reset();

    // Cycle-by-cycle vectors: ASC single-byte packet, then STL grant
    for (int i = 0; i < 8; i++) begin
      asc_valid = tbl[i].av;
      asc_data  = tbl[i].din;
      stl_valid = tbl[i].sv;
      stl_data  = tbl[i].din;
      dbg_valid = 1'b0;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("vec%0d", i),
          {18'b0, out_valid, (tbl[i].ov ? out_data : 8'h00), asc_ready, stl_ready, busy, grant_id},
          {18'b0, tbl[i].ov, (tbl[i].ov ? tbl[i].od : 8'h00), tbl[i].ar, tbl[i].sr, tbl[i].bsy, tbl[i].gid});
      chk($sformatf("vec%0d_dbg_ready", i), {31'b0, dbg_ready}, 32'd0);
      @(negedge clk);
    end

    // STL 16 bytes with out_ready toggling
    do_reset();
    stl_en = 1;
    for (int i = 0; i < 16; i++) stl_q.push_back(8'(i));
    or_toggle = 1; or_phase = 1;
    for (int n = 0; n < 200 && out_q.size() < 17; n++) tick();
    chk("stl_toggle_len", out_q.size(), 17);
    for (int i = 0; i < 17 && i < out_q.size(); i++)
      chk($sformatf("stl_toggle_b%0d", i), {24'b0, out_q[i]}, (i == 0) ? 32'h73 : 32'(i - 1));
    repeat (3) tick();
    chk("stl_toggle_nodup", out_q.size(), 17);

    // All requesters continuously valid: rotation
    do_reset();
    asc_en = 1; stl_en = 1; dbg_en = 1;
    for (int i = 0; i < 8;  i++) asc_q.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 40; i++) stl_q.push_back(8'h30 + 8'(i));
    for (int i = 0; i < 16; i++) dbg_q.push_back(8'h80 + 8'(i));
    or_level = 1;
    for (int n = 0; n < 200 && tag_q.size() < 4; n++) tick();
    chk("rot_count", tag_q.size(), 4);
    if (tag_q.size() >= 4) begin
      chk("rot_tag0", {24'b0, tag_q[0]}, 32'h61);
      chk("rot_tag1", {24'b0, tag_q[1]}, 32'h73);
      chk("rot_tag2", {24'b0, tag_q[2]}, 32'h64);
      chk("rot_tag3", {24'b0, tag_q[3]}, 32'h61);
      chk("rot_gid", {24'b0, gid_q[0], gid_q[1], gid_q[2], gid_q[3]}, {24'b0, 2'd0, 2'd1, 2'd2, 2'd0});
    end

    // DBG stalls after 2 of 4 bytes: padded packet
    do_reset();
    dbg_en = 1;
    dbg_q.push_back(8'h11);
    dbg_q.push_back(8'h22);
    or_level = 1;
    for (int n = 0; n < 100 && out_q.size() < 5; n++) tick();
    repeat (3) tick();
    chk("pad_len", out_q.size(), 5);
    if (out_q.size() >= 5)
      chk("pad_stream", {out_q[0], out_q[1], out_q[2], out_q[3]}, 32'h641122EE);
    if (out_q.size() >= 5)
      chk("pad_last", {24'b0, out_q[4]}, 32'hEE);
    chk("pad_tmo", {24'b0, timeout_count}, 32'd1);
    chk("pad_dbg_ready", pad_ready_seen, 0);
    chk("pad_idle", {31'b0, busy}, 32'd0);

    // Reset asserted during byte 5 of an STL packet
    do_reset();
    stl_en = 1;
    for (int i = 0; i < 16; i++) stl_q.push_back(8'hA0 + 8'(i));
    or_level = 1;
    for (int n = 0; n < 50 && out_q.size() < 5; n++) tick();
    chk("rst_mid_reach", out_q.size(), 5);
    reset = 1'b0;
    #1;
    chk_reset_outs("rst_mid_low0");
    @(negedge clk);
    #1;
    chk_reset_outs("rst_mid_low1");
    @(negedge clk);
    stl_en = 0; stl_q.delete(); stl_valid = 0;
    asc_en = 1; asc_q.push_back(8'h77);
    out_q.delete(); seen_idle = 1'b1;
    reset = 1'b1;
    for (int n = 0; n < 20 && out_q.size() < 2; n++) tick();
    repeat (2) tick();
    chk("rst_mid_len", out_q.size(), 2);
    if (out_q.size() >= 2)
      chk("rst_mid_stream", {16'b0, out_q[0], out_q[1]}, 32'h6177);

    // STL held off by out_ready=0 for 2000 cycles: no timeout
    do_reset();
    stl_en = 1;
    for (int i = 0; i < 16; i++) stl_q.push_back(8'h40 + 8'(i));
    or_level = 1;
    for (int n = 0; n < 20 && out_q.size() < 2; n++) tick();
    or_level = 0;
    repeat (2000) tick();
    chk("bp_tmo", {24'b0, timeout_count}, 32'd0);
    chk("bp_hold", {29'b0, busy, grant_id}, {29'b0, 1'b1, 2'd1});
    chk("bp_len_held", out_q.size(), 2);
    or_level = 1;
    for (int n = 0; n < 100 && out_q.size() < 17; n++) tick();
    chk("bp_len", out_q.size(), 17);
    for (int i = 1; i < 17 && i < out_q.size(); i++)
      chk($sformatf("bp_b%0d", i - 1), {24'b0, out_q[i]}, 32'h40 + 32'(i - 1));
    chk("bp_tmo_end", {24'b0, timeout_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
